// File: rtl/probe_capture_pkg.sv
// Shared types for the logic-analyzer capture core.
// Holds the capture FSM states and the trigger mode encoding.
package probe_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_WAIT_TRIG,
    S_POST,
    S_DONE,
    S_READOUT
  } state_e;

  typedef enum logic [1:0] {
    EQ     = 2'd0,
    NEQ    = 2'd1,
    RISE   = 2'd2,
    CHANGE = 2'd3
  } trig_mode_e;

endpackage

// File: rtl/probe_capture_ram.sv
// Capture buffer: simple dual-port RAM, one write and one registered read.
// Kept free of resets so it maps onto block RAM.
module probe_capture_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // write port and registered read port; rdata holds when re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/probe_capture_core.sv
// On-chip logic-analyzer capture core with pre/post trigger window
// and a valid/ready streaming readout of the circular buffer.
module probe_capture_core
  import probe_capture_pkg::*;
#(
  parameter int NUM_PROBES = 4,
  parameter int PROBE_W    = 16,
  parameter int DEPTH      = 256,
  parameter int PRE_TRIG   = 128,
  localparam int DW = NUM_PROBES * PROBE_W,
  localparam int SW = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW-1:0]      probe,
  input  logic [SW-1:0]      trig_sel,
  input  logic [1:0]         trig_mode,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic               arm,
  input  logic               abort,
  output logic               armed,
  output logic               triggered,
  output logic               done,
  input  logic               rd_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_N  = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_N = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  localparam logic [AW-1:0] PRE_A  = AW'(PRE_TRIG);

  state_e             state;
  logic [DW-1:0]      smp;
  logic [DW-1:0]      rdata;
  logic [PROBE_W-1:0] cur;
  logic [PROBE_W-1:0] prv;
  logic               prv_vld;
  logic [PROBE_W-1:0] diff;
  logic [PROBE_W-1:0] rise_b;
  logic [PROBE_W-1:0] chg_b;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      trig_addr;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      rd_cnt;
  logic               a_vld;
  logic               a_last;
  logic               hit;
  logic               we;
  logic               re;
  logic               adv;

  // register the probe buses once; this is the sample that gets stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) smp <= '0;
    else        smp <= probe;
  end

  // pick the trigger probe out of the registered sample
  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_PROBES; k++)
      if (trig_sel == SW'(k)) cur = smp[k*PROBE_W +: PROBE_W];
  end

  assign diff   = (cur ^ trig_value) & trig_mask;
  assign rise_b = ~prv & cur & trig_mask;
  assign chg_b  = (prv ^ cur) & trig_mask;

  // trigger condition; edge modes need a valid previous sample
  always_comb begin
    hit = 1'b0;
    unique case (trig_mode_e'(trig_mode))
      EQ:     hit = (diff == '0);
      NEQ:    hit = (diff != '0);
      RISE:   hit = prv_vld && (rise_b != '0);
      CHANGE: hit = prv_vld && (chg_b != '0);
    endcase
  end

  assign we  = (state == S_PRE_FILL) || (state == S_WAIT_TRIG)
            || (state == S_POST);
  assign adv = !out_valid || out_ready;
  assign re  = (state == S_READOUT) && adv && (rd_cnt != FULL_N);

  probe_capture_ram #(
    .DEPTH(DEPTH),
    .W    (DW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(smp),
    .re   (re),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  // capture/readout FSM; read pipeline is RAM stage then output stage,
  // both advancing together so a stall freezes everything in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trig_addr <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      prv       <= '0;
      prv_vld   <= 1'b0;
      a_vld     <= 1'b0;
      a_last    <= 1'b0;
      armed     <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      a_vld     <= 1'b0;
      a_last    <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr  <= wr_ptr + 1'b1;
        prv     <= cur;
        prv_vld <= 1'b1;
      end
      unique case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            prv_vld   <= 1'b0;
            triggered <= 1'b0;
            armed     <= 1'b1;
            done      <= 1'b0;
            state     <= (PRE_TRIG == 0) ? S_WAIT_TRIG : S_PRE_FILL;
          end else if (state == S_DONE && rd_start) begin
            rd_ptr <= trig_addr - PRE_A;
            rd_cnt <= '0;
            state  <= S_READOUT;
          end
        end
        S_PRE_FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == PRE_N - 1'b1) state <= S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (hit) begin
            trig_addr <= wr_ptr;
            triggered <= 1'b1;
            cnt       <= '0;
            if (POST_N == '0) begin
              state <= S_DONE;
              armed <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_POST;
            end
          end
        end
        S_POST: begin
          cnt <= cnt + 1'b1;
          if (cnt == POST_N - 1'b1) begin
            state <= S_DONE;
            armed <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_READOUT: begin
          if (re) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
          end
          if (adv) begin
            out_valid <= a_vld;
            out_last  <= a_last;
            a_vld     <= re;
            a_last    <= re && (rd_cnt == FULL_N - 1'b1);
            if (a_vld) out_data <= rdata;
          end
          if (out_valid && out_ready && out_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_probe_capture_core.sv
// Scoreboard bench for probe_capture_core: directed captures with
// hand-derived windows, checked by monitors as beats stream out.
module tb_probe_capture_core;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] probe;
  logic [7:0]  sprobe;
  logic [1:0]  trig_sel;
  logic [1:0]  trig_mode;
  logic [15:0] trig_value;
  logic [15:0] trig_mask;
  logic        arm, abort, rd_start, out_ready;
  logic        armed, triggered, done, out_valid, out_last;
  logic [63:0] out_data;
  logic        rnd;
  int          tick;
  int          checks;
  int          errors;
  beat_t       exp_q[$];
  logic        stall_p;
  logic [63:0] data_p;

  probe_capture_core u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .probe     (probe),
    .trig_sel  (trig_sel),
    .trig_mode (trig_mode),
    .trig_value(trig_value),
    .trig_mask (trig_mask),
    .arm       (arm),
    .abort     (abort),
    .armed     (armed),
    .triggered (triggered),
    .done      (done),
    .rd_start  (rd_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // probe3 = ~t, probe2 bit0 toggles every 3 samples,
  // probe1 = 8-bit wrapping count, probe0 = 16-bit count
  function automatic logic [63:0] mk(input int t);
    logic [15:0] v;
    logic        b;
    v = t[15:0];
    b = ((t / 3) % 2) == 1;
    return {~v, 15'd0, b, 8'd0, v[7:0], v};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick   = 0;
    probe  = mk(0);
    sprobe = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      tick++;
      probe  = mk(tick);
      sprobe = tick[7:0];
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rnd ? 1'($urandom % 2) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // main monitor: pop expected beat on each transfer, and hold
  // data steady across stalls
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && stall_p) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, data_p);
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", out_data, e.d);
        chk("rd_last", out_last, e.l);
      end
    end
    stall_p <= rst_n && out_valid && !out_ready;
    data_p  <= out_data;
  end

  genvar g;
  for (g = 0; g < 2; g++) begin : sm
    localparam int PT = (g == 0) ? 0 : 7;
    logic       s_arm, s_rd, s_armed, s_trig, s_done, s_ov, s_last;
    logic [7:0] s_data;
    logic [8:0] sq[$];
    logic       fin;

    probe_capture_core #(
      .NUM_PROBES(1),
      .PROBE_W   (8),
      .DEPTH     (8),
      .PRE_TRIG  (PT)
    ) u_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .probe     (sprobe),
      .trig_sel  (1'b0),
      .trig_mode ((g == 0) ? 2'd3 : 2'd1),
      .trig_value(8'd0),
      .trig_mask ((g == 0) ? 8'hFF : 8'h07),
      .arm       (s_arm),
      .abort     (1'b0),
      .armed     (s_armed),
      .triggered (s_trig),
      .done      (s_done),
      .rd_start  (s_rd),
      .out_valid (s_ov),
      .out_ready (1'b1),
      .out_data  (s_data),
      .out_last  (s_last)
    );

    always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n && s_ov) begin
        if (sq.size() == 0) begin
          chk("s_unexpected", 1, 0);
        end else begin
          e = sq.pop_front();
          chk("s_data", s_data, e[7:0]);
          chk("s_last", s_last, e[8]);
        end
      end
    end

    // CHANGE with PRE_TRIG=0 fires on t0+1 (no edge on first sample);
    // NEQ with PRE_TRIG=7 armed at t0%8==1 fires on t0+8.
    // Both windows therefore start at t0+1.
    initial begin
      int t0;
      int n;
      fin   = 1'b0;
      s_arm = 1'b0;
      s_rd  = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      n = 0;
      while ((tick % 8) != g && n < 20) begin
        step();
        n++;
      end
      t0    = tick;
      s_arm = 1'b1;
      step();
      s_arm = 1'b0;
      n = 0;
      while (!s_done && n < 60) begin
        step();
        n++;
      end
      chk("s_done", s_done, 1);
      chk("s_trig", s_trig, 1);
      chk("s_armed", s_armed, 0);
      for (int i = 0; i < 8; i++) begin
        logic [7:0] v;
        v = 8'(t0 + 1 + i);
        sq.push_back({i == 7, v});
      end
      s_rd = 1'b1;
      step();
      s_rd = 1'b0;
      n = 0;
      while (sq.size() != 0 && n < 60) begin
        step();
        n++;
      end
      chk("s_drain", sq.size(), 0);
      fin = 1'b1;
    end
  end

  task automatic align(input int m, input int r);
    int n;
    n = 0;
    while ((tick % m) != r && n < m + 4) begin
      step();
      n++;
    end
  endtask

  task automatic arm_cfg(input logic [1:0] sel, input logic [1:0] md,
                         input logic [15:0] val, input logic [15:0] msk,
                         output int t0);
    trig_sel   = sel;
    trig_mode  = md;
    trig_value = val;
    trig_mask  = msk;
    t0         = tick;
    arm        = 1'b1;
    step();
    arm        = 1'b0;
    chk("armed_after_arm", armed, 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic push_win(input int start);
    for (int i = 0; i < 256; i++)
      exp_q.push_back('{d: mk(start + i), l: (i == 255)});
  endtask

  task automatic read_out(input int start, input bit lat);
    int n;
    push_win(start);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    if (lat) begin
      chk("lat_c0", out_valid, 0);
      step();
      chk("lat_c1", out_valid, 0);
      step();
      chk("lat_c2", out_valid, 1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("rd_drain", exp_q.size(), 0);
    step();
    step();
    chk("done_after_rd", done, 1);
    chk("valid_after_rd", out_valid, 0);
  endtask

  initial begin
    int t0;
    int n;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    arm        = 1'b0;
    abort      = 1'b0;
    rd_start   = 1'b0;
    rnd        = 1'b0;
    trig_sel   = 2'd0;
    trig_mode  = 2'd0;
    trig_value = 16'd0;
    trig_mask  = 16'hFFFF;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    chk("rst_armed", armed, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);

    // EQ 300 on probe0: window 172..427, 300 at index 128
    step();
    arm_cfg(2'd0, 2'd0, 16'd300, 16'hFFFF, t0);
    wait_done(700);
    chk("eq_triggered", triggered, 1);
    chk("eq_armed_low", armed, 0);
    read_out(172, 1'b1);
    rnd = 1'b1;
    read_out(172, 1'b0);
    rnd = 1'b0;

    // EQ 5 on 8-bit wrap, armed at t%256==0: prefill hit ignored,
    // fires at t0+261
    align(256, 0);
    arm_cfg(2'd1, 2'd0, 16'd5, 16'hFFFF, t0);
    chk("eq5_trig_clear", triggered, 0);
    wait_done(800);
    read_out(t0 + 261 - 128, 1'b0);

    n = 0;
    while (!(sm[0].fin && sm[1].fin) && n < 500) begin
      step();
      n++;
    end
    chk("small_fin", sm[0].fin && sm[1].fin, 1);

    // abort while in POST
    step();
    arm_cfg(2'd0, 2'd0, 16'(tick + 150), 16'hFFFF, t0);
    n = 0;
    while (!triggered && n < 400) begin
      step();
      n++;
    end
    chk("ab_triggered", triggered, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_armed", armed, 0);
    chk("ab_trig", triggered, 0);
    chk("ab_done", done, 0);

    // RISE on probe2 bit0 armed at t%6==3: fires at t0+132;
    // reset partway through its readout
    align(6, 3);
    arm_cfg(2'd2, 2'd2, 16'd0, 16'h0001, t0);
    wait_done(600);
    push_win(t0 + 4);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (40) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_trig", triggered, 0);
    chk("mid_rst_armed", armed, 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;

    align(6, 3);
    arm_cfg(2'd2, 2'd2, 16'd0, 16'h0001, t0);
    wait_done(600);
    chk("rise_triggered", triggered, 1);
    rnd = 1'b1;
    read_out(t0 + 4, 1'b0);
    rnd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
